// File: rtl/controller_sequencer_pkg.sv
// rtl/controller_sequencer_pkg.sv - shared opcodes, T-state codes and control-word bit indices
package controller_sequencer_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CW_WIDTH = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// rtl/controller_sequencer_ring_counter.sv - 6-bit one-hot ring with enable, async active-low reset
module ring_counter
  import controller_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [5:0] ring
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring <= T1;
    end else if (en) begin
      ring <= {ring[4:0], ring[5]};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - T-state sequencer and control-word decode for a SAP-1 style CPU
module controller_sequencer
  import controller_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output logic [5:0]              o_tstate,
  output logic                    o_cp,
  output logic                    o_ep,
  output logic                    o_lm,
  output logic                    o_ce,
  output logic                    o_li,
  output logic                    o_ei,
  output logic                    o_la,
  output logic                    o_ea,
  output logic                    o_su,
  output logic                    o_eu,
  output logic                    o_lb,
  output logic                    o_lo,
  output logic                    o_hlt
);

  logic [CW_WIDTH-1:0] cw;
  logic                is_lda, is_add, is_sub, is_out, is_hlt;

  assign is_lda = (i_opcode == OPCODE_WIDTH'(OP_LDA));
  assign is_add = (i_opcode == OPCODE_WIDTH'(OP_ADD));
  assign is_sub = (i_opcode == OPCODE_WIDTH'(OP_SUB));
  assign is_out = (i_opcode == OPCODE_WIDTH'(OP_OUT));
  assign is_hlt = (i_opcode == OPCODE_WIDTH'(OP_HLT));

  ring_counter u_ring (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (!o_hlt),
    .ring  (o_tstate)
  );

  // Halt is latched on the T4 edge; the ring advances on that same edge and then freezes at T5.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hlt <= 1'b0;
    end else if (o_tstate == T4 && is_hlt) begin
      o_hlt <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    case (o_tstate)
      T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      T2: cw[CW_CP] = 1'b1;
      T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      T4: begin
        if (is_lda || is_add || is_sub) begin
          cw[CW_EI] = 1'b1;
          cw[CW_LM] = 1'b1;
        end else if (is_out) begin
          cw[CW_EA] = 1'b1;
          cw[CW_LO] = 1'b1;
        end
      end
      T5: begin
        if (is_lda) begin
          cw[CW_CE] = 1'b1;
          cw[CW_LA] = 1'b1;
        end else if (is_add || is_sub) begin
          cw[CW_CE] = 1'b1;
          cw[CW_LB] = 1'b1;
        end
      end
      T6: begin
        if (is_add || is_sub) begin
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
          cw[CW_SU] = is_sub;
        end
      end
      default: cw = '0;
    endcase
    if (o_hlt) begin
      cw = '0;
    end
  end

  assign o_cp = cw[CW_CP];
  assign o_ep = cw[CW_EP];
  assign o_lm = cw[CW_LM];
  assign o_ce = cw[CW_CE];
  assign o_li = cw[CW_LI];
  assign o_ei = cw[CW_EI];
  assign o_la = cw[CW_LA];
  assign o_ea = cw[CW_EA];
  assign o_su = cw[CW_SU];
  assign o_eu = cw[CW_EU];
  assign o_lb = cw[CW_LB];
  assign o_lo = cw[CW_LO];

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - directed self-checking bench for controller_sequencer
module tb_controller_sequencer;

  localparam logic [12:0] H  = 13'h1000;
  localparam logic [12:0] CP = 13'h0800;
  localparam logic [12:0] EP = 13'h0400;
  localparam logic [12:0] LM = 13'h0200;
  localparam logic [12:0] CE = 13'h0100;
  localparam logic [12:0] LI = 13'h0080;
  localparam logic [12:0] EI = 13'h0040;
  localparam logic [12:0] LA = 13'h0020;
  localparam logic [12:0] EA = 13'h0010;
  localparam logic [12:0] SU = 13'h0008;
  localparam logic [12:0] EU = 13'h0004;
  localparam logic [12:0] LB = 13'h0002;
  localparam logic [12:0] LO = 13'h0001;
  localparam logic [12:0] NONE = 13'h0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [5:0] tstate;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controller_sequencer #(.OPCODE_WIDTH(4)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_opcode (opcode),
    .o_tstate (tstate),
    .o_cp     (cp),
    .o_ep     (ep),
    .o_lm     (lm),
    .o_ce     (ce),
    .o_li     (li),
    .o_ei     (ei),
    .o_la     (la),
    .o_ea     (ea),
    .o_su     (su),
    .o_eu     (eu),
    .o_lb     (lb),
    .o_lo     (lo),
    .o_hlt    (hlt)
  );

  function automatic logic [18:0] observed();
    return {tstate, hlt, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  endfunction

  task automatic check(input string tag, input logic [5:0] t_exp, input logic [12:0] cw_exp);
    logic [18:0] obs;
    logic [18:0] exp;
    obs = observed();
    exp = {t_exp, cw_exp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at T1 on a negedge; T1-T3 run with a junk opcode to show it is ignored there.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] junk,
                           input logic [12:0] cw4, input logic [12:0] cw5, input logic [12:0] cw6);
    opcode = junk;
    #1 check({tag, "_t1"}, 6'h01, EP | LM);
    tick();
    check({tag, "_t2"}, 6'h02, CP);
    tick();
    check({tag, "_t3"}, 6'h04, CE | LI);
    tick();
    opcode = op;
    #1 check({tag, "_t4"}, 6'h08, cw4);
    tick();
    #1 check({tag, "_t5"}, 6'h10, cw5);
    tick();
    #1 check({tag, "_t6"}, 6'h20, cw6);
    tick();
  endtask

  initial begin
    logic [3:0] r;
    logic       ok;
    rst_n  = 1'b0;
    opcode = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset_state", 6'h01, EP | LM);
    rst_n = 1'b1;
    #1 check("reset_release", 6'h01, EP | LM);

    run_instr("lda", 4'b0000, 4'b1111, EI | LM, CE | LA, NONE);
    check("lda_wrap", 6'h01, EP | LM);
    run_instr("add", 4'b0001, 4'b1110, EI | LM, CE | LB, EU | LA);
    run_instr("sub", 4'b0010, 4'b1111, EI | LM, CE | LB, EU | LA | SU);
    run_instr("out", 4'b1110, 4'b0010, EA | LO, NONE, NONE);
    run_instr("nop", 4'b0101, 4'b0000, NONE, NONE, NONE);
    check("nop_wrap", 6'h01, EP | LM);

    // HLT: ring moves to T5 on the T4 edge and stays there.
    opcode = 4'b0000;
    tick();
    tick();
    tick();
    opcode = 4'b1111;
    #1 check("hlt_t4", 6'h08, NONE);
    tick();
    check("hlt_set", 6'h10, H);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      tick();
      check("hlt_hold", 6'h10, H);
    end

    rst_n = 1'b0;
    #1 check("hlt_reset", 6'h01, EP | LM);
    rst_n = 1'b1;
    #1 check("hlt_reset_release", 6'h01, EP | LM);

    // ADD up to T5, then asynchronous reset pulse between edges.
    opcode = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    #1 check("add_pre_reset_t5", 6'h10, CE | LB);
    rst_n = 1'b0;
    #1 check("async_reset_t5", 6'h01, EP | LM);
    rst_n = 1'b1;
    #1 check("async_reset_release", 6'h01, EP | LM);
    tick();
    check("first_edge_t2", 6'h02, CP);
    repeat (5) tick();
    check("post_reset_wrap", 6'h01, EP | LM);

    // Random opcode stream; HLT is replaced so the ring keeps turning.
    for (int i = 0; i < 10000; i++) begin
      r = 4'($urandom_range(0, 15));
      opcode = (r == 4'b1111) ? 4'b0000 : r;
      #1;
      ok = $onehot(tstate) && ($countones({ep, ce, ei, ea, eu}) <= 1) && !hlt;
      checks++;
      assert (ok === 1'b1) else begin
        errors++;
        $error("FAIL rand_invariants observed=%b expected=1 tstate=%h", ok, tstate);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL take parameter OPCODE_WIDTH, default 4, giving the width of the instruction-register opcode field.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_opcode, input, OPCODE_WIDTH bits: the opcode from the instruction register upper nibble.
REQ-005 The block SHALL have port o_tstate, output, 6 bits: one-hot ring state; bit0=T1 through bit5=T6.
REQ-006 The block SHALL have port o_cp, output, 1 bit: increments the program counter.
REQ-007 The block SHALL have port o_ep, output, 1 bit: program counter drives the bus.
REQ-008 The block SHALL have ports o_lm, o_ce, o_li, o_ei, output, 1 bit each: load MAR, RAM drives bus, load IR, IR address field drives bus.
REQ-009 The block SHALL have ports o_la, o_ea, o_su, o_eu, o_lb, o_lo, output, 1 bit each: load A, A drives bus, subtract select, ALU drives bus, load B, load output register.
REQ-010 The block SHALL have port o_hlt, output, 1 bit: CPU halted.

Function
REQ-011 All control outputs SHALL be active-high and SHALL be decoded combinationally from the registered ring state and i_opcode; the downstream registers sample them on the next rising edge.
REQ-012 The ring SHALL advance T1->T2->...->T6->T1 on each rising edge while o_hlt=0.
REQ-013 T1 SHALL assert o_ep and o_lm; T2 SHALL assert o_cp; T3 SHALL assert o_ce and o_li. T1-T3 are opcode-independent.
REQ-014 LDA (0000): T4 asserts o_ei and o_lm; T5 asserts o_ce and o_la; T6 asserts nothing.
REQ-015 ADD (0001): T4 asserts o_ei and o_lm; T5 asserts o_ce and o_lb; T6 asserts o_eu and o_la.
REQ-016 SUB (0010): same as ADD, plus o_su asserted in T6.
REQ-017 OUT (1110): T4 asserts o_ea and o_lo; T5 and T6 assert nothing.
REQ-018 HLT (1111): in T4, o_hlt SHALL be set at the next rising edge; the ring then freezes at T5 with all control outputs 0 except o_hlt, which stays 1.
REQ-019 Any other opcode SHALL be a NOP: T4-T6 assert nothing, and the ring continues.
REQ-020 No more than one bus-driver enable (o_ep, o_ce, o_ei, o_ea, o_eu) SHALL be high in any state.
REQ-021 While o_hlt=1, every control output except o_hlt SHALL be 0, regardless of i_opcode.
REQ-022 i_opcode changes outside T4-T6 SHALL have no effect on the outputs.

Reset
REQ-023 Asserting i_rst_n=0 SHALL immediately force o_tstate=6'b000001 (T1) and o_hlt=0, including mid-instruction and while halted.
REQ-024 After i_rst_n deasserts, the first rising edge SHALL advance to T2. T1 outputs (o_ep, o_lm) are valid during reset release.
REQ-025 Reset is the only exit from halt.

Structure
REQ-026 A shared package SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the T-state one-hot constants, and the control-word bit indices.
REQ-027 The block SHALL contain one sub-module, ring_counter: a 6-bit one-hot ring with enable and asynchronous active-low reset. Decode logic SHALL live in controller_sequencer.
REQ-028 No other sub-modules SHALL be instantiated.

Verification
REQ-029 Reset, then 6 clocks with i_opcode=0000: the bench SHALL see o_tstate=01,02,04,08,10,20 and then 01 again, with LDA outputs exactly per REQ-013/014.
REQ-030 i_opcode=0010 at T6: the bench SHALL see o_la=1, o_eu=1, o_su=1, and all other outputs 0.
REQ-031 i_opcode=1111: the bench SHALL see o_hlt=1 after the T4 edge and o_tstate=0x10 held for 20 further clocks, with all other controls 0.
REQ-032 i_rst_n pulsed low asynchronously mid-T5 of ADD: the bench SHALL see o_tstate=0x01 and o_hlt=0 before the next edge, with o_ep=1 and o_lm=1.
REQ-033 i_opcode=0101 (undefined): the bench SHALL see T4-T6 with all controls 0 and the ring returning to T1.
REQ-034 A random opcode stream over 10k cycles SHALL show the one-hot and single-bus-driver assertions (REQ-005, REQ-020) always holding.
